// File: rtl/decode_pkg.sv
// Shared types and helpers for the decode_sweep select decoder / sweep sequencer.
// Optional out-of-range error pulse is enabled by defining DECODE_SWEEP_ERR_EN.
package decode_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // Ceiling log2 for parameter derivation (returns at least 1 for n >= 2).
    function automatic int clog2_f(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/decode_onehot.sv
// Combinational index-to-one-hot converter; indices at or beyond NUM_OUT
// decode to all-zero.
module decode_onehot #(
    parameter int NUM_OUT = 8,
    parameter int IDX_W   = 4
) (
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_OUT-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (idx_i == IDX_W'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_sweep.sv
// Registered select-to-one-hot decoder with a built-in sweep sequencer.
// Define DECODE_SWEEP_ERR_EN to add the err_o out-of-range select pulse.
module decode_sweep
    import decode_pkg::*;
#(
    parameter  int NUM_OUT = 8,
    localparam int SEL_W   = clog2_f(NUM_OUT)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               sweep_start_i,
    output logic [NUM_OUT-1:0] out_o,
    output logic               busy_o,
    output logic               done_o
`ifdef DECODE_SWEEP_ERR_EN
    ,
    output logic               err_o
`endif
);

    // One extra bit so the terminal index NUM_OUT is representable even
    // when NUM_OUT is a power of two.
    localparam int IDX_W = SEL_W + 1;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_OUT-1:0]   out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [IDX_W-1:0]     dec_idx;
    logic                 dec_en;
    logic [NUM_OUT-1:0]   dec_onehot;
`ifdef DECODE_SWEEP_ERR_EN
    logic                 err_q, err_d;
`endif

    decode_onehot #(
        .NUM_OUT (NUM_OUT),
        .IDX_W   (IDX_W)
    ) u_onehot (
        .idx_i    (dec_idx),
        .onehot_o (dec_onehot)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dec_idx = '0;
        dec_en  = 1'b0;
`ifdef DECODE_SWEEP_ERR_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // A sweep request takes priority; a coincident en is dropped.
                if (sweep_start_i) begin
                    state_d = SWEEP;
                    dec_idx = '0;
                    dec_en  = 1'b1;
                    idx_d   = IDX_W'(1);
                    busy_d  = 1'b1;
                end else if (en_i) begin
                    dec_idx = {1'b0, sel_i};
                    dec_en  = 1'b1;
`ifdef DECODE_SWEEP_ERR_EN
                    err_d   = ({1'b0, sel_i} >= IDX_W'(NUM_OUT));
`endif
                end
            end
            SWEEP: begin
                if (idx_q == IDX_W'(NUM_OUT)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    dec_idx = idx_q;
                    dec_en  = 1'b1;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
        out_d = dec_en ? dec_onehot : '0;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DECODE_SWEEP_ERR_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

    assign out_o  = out_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_decode_sweep.sv
// Self-checking bench for decode_sweep: two instances (NUM_OUT=8 and 6) share
// stimulus and are checked every cycle against a per-instance reference model.
module tb_decode_sweep;

    typedef struct packed {
        logic [7:0] out;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] sel;
    logic       ss;
    logic [7:0] out8;
    logic [5:0] out6;
    logic       busy8, busy6, done8, done6;
`ifdef DECODE_SWEEP_ERR_EN
    logic       err8, err6;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   pos8 = -1;
    int   pos6 = -1;
    exp_t e8 = '0;
    exp_t e6 = '0;

    decode_sweep #(.NUM_OUT(8)) dut8 (
        .clk_i         (clk),
        .reset_i       (reset),
        .en_i          (en),
        .sel_i         (sel),
        .sweep_start_i (ss),
        .out_o         (out8),
        .busy_o        (busy8),
        .done_o        (done8)
`ifdef DECODE_SWEEP_ERR_EN
        ,
        .err_o         (err8)
`endif
    );

    decode_sweep #(.NUM_OUT(6)) dut6 (
        .clk_i         (clk),
        .reset_i       (reset),
        .en_i          (en),
        .sel_i         (sel),
        .sweep_start_i (ss),
        .out_o         (out6),
        .busy_o        (busy6),
        .done_o        (done6)
`ifdef DECODE_SWEEP_ERR_EN
        ,
        .err_o         (err6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pos: strobes already emitted in the current sweep, -1 when idle.
    function automatic void predict(input int n, inout int pos, input logic en_s,
                                    input int sel_s, input logic ss_s, output exp_t e);
        e = '0;
        if (pos < 0) begin
            if (ss_s) begin
                e.out  = 8'(1);
                e.busy = 1'b1;
                pos    = 1;
            end else if (en_s) begin
                if (sel_s < n) e.out = 8'(1 << sel_s);
                else           e.err = 1'b1;
            end
        end else if (pos < n) begin
            e.out  = 8'(1 << pos);
            e.busy = 1'b1;
            pos    = pos + 1;
        end else begin
            e.done = 1'b1;
            pos    = -1;
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out8",  out8, e8.out);
        chk("busy8", {7'd0, busy8}, {7'd0, e8.busy});
        chk("done8", {7'd0, done8}, {7'd0, e8.done});
        chk("onehot8", {7'd0, $onehot0(out8)}, 8'd1);
        chk("out6",  {2'd0, out6}, e6.out);
        chk("busy6", {7'd0, busy6}, {7'd0, e6.busy});
        chk("done6", {7'd0, done6}, {7'd0, e6.done});
        chk("onehot6", {7'd0, $onehot0(out6)}, 8'd1);
`ifdef DECODE_SWEEP_ERR_EN
        chk("err8", {7'd0, err8}, {7'd0, e8.err});
        chk("err6", {7'd0, err6}, {7'd0, e6.err});
`endif
    endtask

    // Inputs are already stable; advance one edge, update models, check.
    task automatic step();
        @(posedge clk);
        cyc++;
        predict(8, pos8, en, int'(sel), ss, e8);
        predict(6, pos6, en, int'(sel), ss, e6);
        #1;
        check_all();
    endtask

    task automatic drive(input logic en_v, input logic [2:0] sel_v, input logic ss_v);
        en  = en_v;
        sel = sel_v;
        ss  = ss_v;
        step();
    endtask

    // Called at posedge+1: pulse reset between edges and check the async clear.
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1;
        e8 = '0;
        e6 = '0;
        pos8 = -1;
        pos6 = -1;
        check_all();
        #2 reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (pos8 >= 0 || pos6 >= 0) drive(1'b0, 3'd0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        sel   = 3'd0;
        ss    = 1'b0;
        #1;
        check_all();
        #12 reset = 1'b0;
        step();

        // decode every select, back to back, then idle
        for (int i = 0; i < 8; i++) drive(1'b1, 3'(i), 1'b0);
        drive(1'b0, 3'd3, 1'b0);

        // sweep with en noise during it
        drive(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, 3'($urandom_range(7)), 1'b0);
        drain();

        // coincident en sel=5 and sweep_start: sweep must win
        drive(1'b1, 3'd5, 1'b1);
        drain();

        // sweep_start held: back-to-back sweeps restart in the done cycle
        for (int i = 0; i < 20; i++) drive(1'b0, 3'd0, 1'b1);
        drive(1'b0, 3'd0, 1'b0);
        drain();

        // reset after the third strobe, then a clean restart
        drive(1'b0, 3'd0, 1'b1);
        drive(1'b0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b0);
        mid_reset();
        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b1);
        drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(1)), 3'($urandom_range(7)),
                  1'($urandom_range(15) == 0));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_sweep.md
# decode_sweep

Parametrised, registered select-to-one-hot decoder with a built-in sweep sequencer. Converts a binary select into a single-cycle one-hot strobe (register-file write enables, bank selects) and, on request, walks a one-hot strobe across every output in turn so that the register file can be cleared or initialised after reset without a separate controller. Sits between the control unit and the register file / memory-bank enable logic.

## Interface
- NUM_OUT, default 8: number of one-hot outputs; legal range 2..256, need not be a power of two.
- SEL_W, derived as ceil(log2(NUM_OUT)), not overridable: select width.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  decode request, sampled each rising edge.
- sel  input  SEL_W  binary index decoded when en is sampled high.
- sweep_start  input  1  request a full sweep, sampled each rising edge.
- out  output  NUM_OUT  registered one-hot strobe (all-zero when idle).
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- err  output  1  one-cycle pulse on out-of-range select (present only with DECODE_SWEEP_ERR_EN).

## Operation
- All outputs registered; reset forces out=0, busy=0, done=0, err=0, state IDLE, sweep index 0.
- States: IDLE, SWEEP.
- IDLE, sweep_start=1: enter SWEEP, out<=onehot(0), index<=1, busy<=1. Any en on the same edge is dropped (sweep wins).
- IDLE, sweep_start=0, en=1, sel<NUM_OUT: out<=onehot(sel) for exactly one cycle.
- IDLE, en=1, sel>=NUM_OUT: out<=0; err<=1 if the macro is defined.
- IDLE, en=0: out<=0.
- SWEEP, index<NUM_OUT: out<=onehot(index), index<=index+1.
- SWEEP, index==NUM_OUT: out<=0, busy<=0, done<=1, index<=0, return to IDLE.
- In SWEEP, en and sweep_start are ignored (no queueing); err never asserts.
- done and err are cleared on the next edge unless re-triggered.
- Index counter is SEL_W+1 bits wide so that NUM_OUT=2^SEL_W terminates without wrap.
- Reset mid-sweep: immediate abort; out=0, busy=0, no done pulse.
- Invariant: out is zero or has exactly one bit set, every cycle.

## Timing
- Decode latency 1: en/sel sampled at edge k yields out valid after edge k, held one cycle.
- Back-to-back en with changing sel produces one strobe per cycle, no bubble.
- Sweep: sampled at edge k; onehot(i) is visible in the cycle after edge k+i for i=0..NUM_OUT-1; busy is high for exactly NUM_OUT cycles; done is high in the cycle after edge k+NUM_OUT.
- sweep_start may be reasserted in the done cycle (state is IDLE); a new sweep starts with no gap.

## Configuration
- DECODE_SWEEP_ERR_EN defined: err port exists and pulses one cycle for each sampled en with sel>=NUM_OUT in IDLE.
- Undefined: no err port, no error logic; out-of-range selects are silently decoded to all-zero.

## Structure
- Package decode_pkg: state encoding constants (IDLE, SWEEP), ceiling-log2 function used to derive SEL_W.
- Sub-module decode_onehot (combinational, parametrised by NUM_OUT): index to one-hot, zero when index>=NUM_OUT; instantiated once and fed by a mux of sel and the sweep index.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> out=0, busy=0, done=0 immediately.
- NUM_OUT=8, en=1 with sel=0..7 on consecutive cycles -> out=01,02,04,...,80 one cycle later each; en=0 -> out=00.
- NUM_OUT=8, sweep_start pulse -> busy high 8 cycles, out=01..80 in sequence, then out=00 with done=1 for one cycle; en pulses during the sweep have no effect.
- Simultaneous en=1,sel=5 and sweep_start=1 -> sweep runs, out starts at 01, no 0x20 strobe.
- NUM_OUT=6 with DECODE_SWEEP_ERR_EN, en=1 sel=6 -> out=000000, err=1 for one cycle; sweep -> 6 strobes then done.
- Reset asserted after the third sweep strobe -> out=0, busy=0, done never pulses; a subsequent sweep_start begins again at onehot(0).
